// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector: runtime pattern of 1..PAT_W bits, overlapping or non-overlapping matches.
// Latency 1: out rises the cycle after the edge that sampled the completing bit; out is a pure register.
// No backpressure: in is consumed whenever in_valid is high; cfg_load takes priority and flushes history.
// Optional macro SEQ_PATTERN_DETECTOR_MATCH_CNT_EN builds the saturating match counter (else match_cnt = 0).
module seq_pattern_detector #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             in_valid,
  input  logic             in,
  output logic             out,
  output logic             cfg_err,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_MATCH, S_DISABLED} state_t;

  state_t           state, state_nxt;
  logic [PAT_W-1:0] pat_q, hist_q, hist_nxt, mask;
  logic [LEN_W-1:0] len_q, fill_q, fill_nxt;
  logic             ovl_q;
  logic             cfg_legal, bit_ok, hit, out_nxt;
  logic [LEN_W:0]   fill_p1;

  // A length of zero or longer than the history cannot ever be compared.
  assign cfg_legal = (cfg_len != '0) && ({1'b0, cfg_len} <= (LEN_W + 1)'(PAT_W));
  // A bit only enters the history when no reconfiguration competes and the config is usable.
  assign bit_ok    = in_valid && !cfg_load && (state != S_DISABLED);
  assign hist_nxt  = {hist_q[PAT_W-2:0], in};
  // One extra bit so fill+1 never wraps when PAT_W+1 is a power of two.
  assign fill_p1   = {1'b0, fill_q} + 1'b1;

  // Select the low len bits of history/pattern for comparison.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  // Enough fresh bits seen, and the newest len bits (including this one) equal the pattern.
  assign hit = (fill_p1 >= {1'b0, len_q}) && ((hist_nxt & mask) == (pat_q & mask));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and fill-count logic.
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_q;
    if (cfg_load) begin
      state_nxt = cfg_legal ? S_IDLE : S_DISABLED;
      fill_nxt  = '0;
    end else if (bit_ok) begin
      if (hit) begin
        state_nxt = S_MATCH;
        // Overlap keeps the window full; non-overlap demands len fresh bits again.
        fill_nxt  = ovl_q ? len_q : '0;
      end else begin
        fill_nxt  = (fill_p1 > {1'b0, len_q}) ? len_q : fill_p1[LEN_W-1:0];
        state_nxt = (fill_nxt == '0) ? S_IDLE : S_FILL;
      end
    end
  end

  // Output decode: out only reflects a valid bit that completed a match this cycle.
  always_comb begin
    out_nxt = bit_ok && hit;
  end

  // Active config, history, fill and registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q   <= '1;
      len_q   <= LEN_W'(2);
      ovl_q   <= 1'b1;
      hist_q  <= '0;
      fill_q  <= '0;
      out     <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      fill_q <= fill_nxt;
      out    <= out_nxt;
      if (cfg_load) begin
        pat_q   <= cfg_pattern;
        len_q   <= cfg_len;
        ovl_q   <= cfg_overlap;
        hist_q  <= '0;
        cfg_err <= !cfg_legal;
      end else if (bit_ok) begin
        hist_q <= hist_nxt;
      end
    end
  end

`ifdef SEQ_PATTERN_DETECTOR_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of matches since the last reset or cfg_load.
  always_ff @(posedge clk) begin
    if (reset || cfg_load)            cnt_q <= '0;
    else if (out_nxt && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: bit-queue reference model checked every cycle plus literal expectations.
module tb_seq_pattern_detector;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 2;
`ifdef SEQ_PATTERN_DETECTOR_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic             in_valid = 1'b0;
  logic             in = 1'b0;
  logic             out;
  logic             cfg_err;
  logic [CNT_W-1:0] match_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  seq_pattern_detector #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in(in),
    .out(out), .cfg_err(cfg_err), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: queue of bits accepted since the last flush; a match is the
  // newest len bits equalling the pattern (pattern bit 0 = newest bit).
  bit               q_bits[$];
  logic [PAT_W-1:0] m_pat;
  int               m_len;
  bit               m_ovl, m_dis, hitm;
  bit               exp_out, exp_err;
  int               exp_cnt;

  always @(posedge clk) begin
    if (reset) begin
      m_pat = '1; m_len = 2; m_ovl = 1'b1; m_dis = 1'b0;
      q_bits.delete();
      exp_out = 1'b0; exp_err = 1'b0; exp_cnt = 0;
    end else if (cfg_load) begin
      m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
      m_dis = (m_len == 0) || (m_len > PAT_W);
      exp_err = m_dis;
      q_bits.delete();
      exp_out = 1'b0; exp_cnt = 0;
    end else if (in_valid && !m_dis) begin
      q_bits.push_back(in);
      if (q_bits.size() > PAT_W) void'(q_bits.pop_front());
      hitm = 1'b0;
      if (q_bits.size() >= m_len) begin
        hitm = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (q_bits[q_bits.size() - 1 - k] != m_pat[k]) hitm = 1'b0;
      end
      exp_out = hitm;
      if (hitm) begin
        if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        if (!m_ovl) q_bits.delete();
      end
    end else begin
      exp_out = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_out", out, exp_out);
      cmp("model_cfg_err", cfg_err, exp_err);
      cmp("model_match_cnt", match_cnt, CNT_EN ? exp_cnt : 0);
    end
  end

  // Present one valid bit and check the literal expected out one cycle later.
  task automatic send(input bit v, input bit exp_o);
    cfg_load = 1'b0; in_valid = 1'b1; in = v;
    @(negedge clk);
    cmp("lit_out", out, exp_o);
  endtask

  task automatic gap();
    cfg_load = 1'b0; in_valid = 1'b0; in = 1'($urandom);
    @(negedge clk);
    cmp("lit_gap_out", out, 0);
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input int len, input bit ovl, input bit with_bit);
    cfg_load = 1'b1; cfg_pattern = p; cfg_len = LEN_W'(len); cfg_overlap = ovl;
    in_valid = with_bit; in = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0; in_valid = 1'b0;
    cmp("lit_load_out", out, 0);
  endtask

  task automatic send_seq(input logic [15:0] bits, input logic [15:0] exps, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i], exps[i]);
  endtask

  initial begin
    @(negedge clk);
    chk_en = 1'b1;
    cmp("rst_out", out, 0);
    cmp("rst_cfg_err", cfg_err, 0);
    cmp("rst_cnt", match_cnt, 0);
    reset = 1'b0;

    // Legacy two-ones default.
    send_seq(16'b01110, 16'b00110, 5);
    cmp("lit_cnt_default", match_cnt, CNT_EN ? 2 : 0);

    // Overlapping 1011.
    load(8'b1011, 4, 1'b1, 1'b0);
    send_seq(16'b1011011, 16'b0001001, 7);
    cmp("lit_cnt_overlap", match_cnt, CNT_EN ? 2 : 0);

    // Non-overlapping 1011.
    load(8'b1011, 4, 1'b0, 1'b0);
    send_seq(16'b1011011, 16'b0001000, 7);
    cmp("lit_cnt_nonoverlap", match_cnt, CNT_EN ? 1 : 0);

    // Gaps between bits.
    load(8'b1011, 4, 1'b1, 1'b0);
    send(1, 0); gap(); send(0, 0); gap(); gap(); send(1, 0); gap(); send(1, 1); gap();

    // cfg_load together with the completing bit: bit dropped, history flushed.
    send_seq(16'b101, 16'b000, 3);
    load(8'b1011, 4, 1'b1, 1'b1);
    send_seq(16'b1011, 16'b0001, 4);

    // Illegal lengths disable detection.
    load(8'hFF, 0, 1'b1, 1'b0);
    cmp("lit_err_len0", cfg_err, 1);
    send_seq(16'b1111, 16'b0000, 4);
    load(8'hFF, PAT_W + 1, 1'b1, 1'b0);
    cmp("lit_err_len9", cfg_err, 1);
    send_seq(16'h03FF, 16'h0000, 10);
    load(8'b11, 2, 1'b1, 1'b0);
    cmp("lit_err_clear", cfg_err, 0);
    send_seq(16'b11, 16'b01, 2);

    // len=1 boundary and counter saturation.
    load(8'b1, 1, 1'b1, 1'b0);
    send_seq(16'b11111, 16'b11111, 5);
    cmp("lit_cnt_sat", match_cnt, CNT_EN ? 3 : 0);

    // len=PAT_W boundary.
    load(8'hA5, PAT_W, 1'b1, 1'b0);
    send_seq(16'hA5, 16'h01, 8);

    // Reset mid-stream wins over cfg_load and in_valid.
    load(8'b11, 2, 1'b1, 1'b0);
    send_seq(16'b11, 16'b01, 2);
    reset = 1'b1; cfg_load = 1'b1; cfg_len = '0; in_valid = 1'b1; in = 1'b1;
    @(negedge clk);
    cmp("lit_rst_out", out, 0);
    cmp("lit_rst_cnt", match_cnt, 0);
    reset = 1'b0; cfg_load = 1'b0; in_valid = 1'b0;
    load(8'hFF, 0, 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    cmp("lit_rst_err", cfg_err, 0);
    reset = 1'b0;
    send_seq(16'b011, 16'b001, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
